// File: rtl/kbd_spi_matrix_pkg.sv
// kbd_spi_matrix_pkg: shared encodings and sizes for the keyboard SPI matrix receiver
package kbd_spi_matrix_pkg;
  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;
  localparam int CTRL_RST   = 0;
  localparam int CTRL_MAGIC = 1;
  localparam int CTRL_TURBO = 2;
  localparam int FRAME_LEN  = 48;
  localparam int ROW_W      = 5;
  localparam int ROWS       = 8;
  localparam int SETTLE_CYC = 3;
endpackage

// File: rtl/kbd_spi_matrix_if.sv
// kbd_spi_matrix_if: SPI link, CPU row select and matrix/control outputs
interface kbd_spi_matrix_if;
  logic       KBD_CLK;
  logic       KBD_CS;
  logic       KBD_DI;
  logic [7:0] A_HI;
  logic [4:0] KEYS;
  logic [7:0] CTRL;
  logic       FRAME_OK;
  logic       FRAME_ERR;
  modport master (output KBD_CLK, KBD_CS, KBD_DI, A_HI, input KEYS, CTRL, FRAME_OK, FRAME_ERR);
  modport slave  (input KBD_CLK, KBD_CS, KBD_DI, A_HI, output KEYS, CTRL, FRAME_OK, FRAME_ERR);
endinterface

// File: rtl/kbd_spi_matrix_sync_edge.sv
// kbd_sync_edge: 2-flop synchroniser (reset high) plus one delay flop for edge detection
module kbd_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] s_q;
  // shift the async input through two sync stages and one history stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 3'b111;
    else s_q <= {s_q[1:0], d_i};
  end
  assign q_o    = s_q[1];
  assign rise_o = s_q[1] & ~s_q[2];
  assign fall_o = ~s_q[1] & s_q[2];
endmodule

// File: rtl/kbd_spi_matrix.sv
// kbd_spi_matrix: SPI-slave frame receiver holding the ZX key matrix and control byte
module kbd_spi_matrix
  import kbd_spi_matrix_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_LEN,
  parameter int TIMEOUT_CYC = 14000
) (
  input logic CLK_14MHZ,
  input logic RESET,
  kbd_spi_matrix_if.slave bus
);
  logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, di_s, di_rise, di_fall;
  logic unused_edges;
  state_t state_q, state_d;
  logic [5:0] bit_q, bit_d;
  logic [13:0] to_q, to_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [ROWS*ROW_W-1:0] mat_q;
  logic [7:0] ctrl_q;
  logic ok_q, ok_d, err_q, err_d;
  logic [4:0] keys;
  kbd_sync_edge u_sclk (.clk(CLK_14MHZ), .rst(RESET), .d_i(bus.KBD_CLK), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
  kbd_sync_edge u_cs   (.clk(CLK_14MHZ), .rst(RESET), .d_i(bus.KBD_CS),  .q_o(cs_s),   .rise_o(cs_rise),   .fall_o(cs_fall));
  kbd_sync_edge u_di   (.clk(CLK_14MHZ), .rst(RESET), .d_i(bus.KBD_DI),  .q_o(di_s),   .rise_o(di_rise),   .fall_o(di_fall));
  assign unused_edges = ^{sclk_s, sclk_fall, di_rise, di_fall};
  // frame FSM; a same-cycle SCLK and CS rise shifts the bit before the count is judged.
  // WAIT_HIGH also waits for CS to read high for SETTLE_CYC cycles, because the
  // synchroniser comes out of reset reading high even when the pin is held low
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    to_d    = to_q;
    shift_d = shift_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      WAIT_HIGH: begin
        to_d = cs_s ? to_q + 14'd1 : '0;
        if (cs_s && to_q == 14'(SETTLE_CYC - 1)) begin
          state_d = IDLE;
          to_d    = '0;
        end
      end
      IDLE: if (cs_fall) begin
        state_d = SHIFT;
        bit_d   = '0;
        to_d    = '0;
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_LEN-2:0], di_s};
          bit_d   = (bit_q == 6'd63) ? bit_q : bit_q + 6'd1;
          to_d    = '0;
        end else to_d = (to_q == 14'(TIMEOUT_CYC)) ? to_q : to_q + 14'd1;
        if (cs_rise) begin
          state_d = IDLE;
          ok_d    = bit_d == 6'(FRAME_BITS);
          err_d   = bit_d != 6'(FRAME_BITS);
        end else if (to_q == 14'(TIMEOUT_CYC)) begin
          state_d = WAIT_HIGH;
          err_d   = 1'b1;
          to_d    = '0;
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end
  // state, counters, shift register and the committed matrix/control image
  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) begin
      state_q <= WAIT_HIGH;
      bit_q   <= '0;
      to_q    <= '0;
      shift_q <= '0;
      mat_q   <= '1;
      ctrl_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      to_q    <= to_d;
      shift_q <= shift_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      if (ok_d) begin
        mat_q  <= shift_d[ROWS*ROW_W-1:0];
        ctrl_q <= shift_d[FRAME_LEN-1:FRAME_LEN-8];
      end
    end
  end
  // AND together every row whose address line is low; nothing selected reads all released
  always_comb begin
    keys = '1;
    for (int r = 0; r < ROWS; r++) if (!bus.A_HI[r]) keys = keys & mat_q[ROW_W*r +: ROW_W];
  end
  assign bus.KEYS      = keys;
  assign bus.CTRL      = ctrl_q;
  assign bus.FRAME_OK  = ok_q;
  assign bus.FRAME_ERR = err_q;
endmodule

// File: tb/tb_kbd_spi_matrix.sv
// tb_kbd_spi_matrix: directed frames plus table-driven row-select checks
module tb_kbd_spi_matrix;
  localparam int TO = 14000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  kbd_spi_matrix_if bus ();
  kbd_spi_matrix #(.FRAME_BITS(48), .TIMEOUT_CYC(TO)) dut (.CLK_14MHZ(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.FRAME_OK) ok_cnt++;
    if (bus.FRAME_ERR) err_cnt++;
  end
  typedef struct {
    int         ph;
    logic [7:0] a;
    logic [4:0] k;
  } vec_t;
  vec_t tab[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic run_tab(input int ph);
    for (int i = 0; i < 14; i++) if (tab[i].ph == ph) begin
      @(negedge clk);
      bus.A_HI = tab[i].a;
      @(negedge clk);
      chk($sformatf("keys_ph%0d_a%02h", ph, tab[i].a), 32'(bus.KEYS), 32'(tab[i].k));
    end
  endtask
  task automatic shift_bits(input int n, input logic [63:0] d);
    for (int i = n - 1; i >= 0; i--) begin
      bus.KBD_CLK = 1'b0;
      bus.KBD_DI  = d[i];
      repeat (2) @(negedge clk);
      bus.KBD_CLK = 1'b1;
      repeat (2) @(negedge clk);
    end
    bus.KBD_CLK = 1'b0;
  endtask
  task automatic send_frame(input int n, input logic [63:0] d);
    @(negedge clk);
    bus.KBD_CS = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(n, d);
    repeat (4) @(negedge clk);
    bus.KBD_CS = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  initial begin
    int o0, e0, n;
    logic [63:0] f1, f2;
    f1 = {16'h0, 8'h04, 40'hFF_FFFF_FFFE};
    f2 = {16'h0, 8'h03, 40'hFF_FFFF_EFBF};
    tab[0]  = '{0, 8'h00, 5'b11111};
    tab[1]  = '{1, 8'hFE, 5'b11110};
    tab[2]  = '{1, 8'hFD, 5'b11111};
    tab[3]  = '{1, 8'h00, 5'b11110};
    tab[4]  = '{1, 8'hFF, 5'b11111};
    tab[5]  = '{2, 8'hF9, 5'b11001};
    tab[6]  = '{2, 8'hFF, 5'b11111};
    tab[7]  = '{2, 8'hFE, 5'b11111};
    tab[8]  = '{2, 8'hFB, 5'b11011};
    tab[9]  = '{2, 8'hFD, 5'b11101};
    tab[10] = '{3, 8'hF9, 5'b11001};
    tab[11] = '{3, 8'h7F, 5'b11111};
    tab[12] = '{4, 8'hFE, 5'b11110};
    tab[13] = '{5, 8'h00, 5'b11111};
    bus.KBD_CLK = 1'b0;
    bus.KBD_CS  = 1'b1;
    bus.KBD_DI  = 1'b0;
    bus.A_HI    = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_ctrl", 32'(bus.CTRL), 32'h00);
    chk("reset_ok", 32'(ok_cnt), 0);
    chk("reset_err", 32'(err_cnt), 0);
    run_tab(0);
    send_frame(48, f1);
    chk("f1_ok", 32'(ok_cnt), 1);
    chk("f1_err", 32'(err_cnt), 0);
    chk("f1_ctrl", 32'(bus.CTRL), 32'h04);
    run_tab(1);
    send_frame(48, f2);
    chk("f2_ok", 32'(ok_cnt), 2);
    chk("f2_ctrl", 32'(bus.CTRL), 32'h03);
    run_tab(2);
    send_frame(47, 64'h0000_5A5A_0000_0000);
    chk("short_err", 32'(err_cnt), 1);
    chk("short_ok", 32'(ok_cnt), 2);
    chk("short_ctrl", 32'(bus.CTRL), 32'h03);
    send_frame(49, 64'h0001_A5A5_0000_0000);
    chk("long_err", 32'(err_cnt), 2);
    chk("long_ok", 32'(ok_cnt), 2);
    chk("long_ctrl", 32'(bus.CTRL), 32'h03);
    run_tab(3);
    @(negedge clk);
    bus.KBD_CS = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(20, 64'hFFFFF);
    e0 = err_cnt;
    n = 2;
    while (!bus.FRAME_ERR && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_fired", 32'(bus.FRAME_ERR), 32'h1);
    total++;
    if (n < TO || n > TO + 10) begin
      bad++;
      $display("FAIL timeout_latency actual=%0d required=%0d..%0d", n, TO, TO + 10);
    end
    repeat (5) @(negedge clk);
    bus.KBD_CS = 1'b1;
    repeat (20) @(negedge clk);
    chk("timeout_single_err", 32'(err_cnt), 32'(e0 + 1));
    chk("timeout_ctrl", 32'(bus.CTRL), 32'h03);
    send_frame(48, f1);
    chk("after_to_ok", 32'(ok_cnt), 3);
    chk("after_to_ctrl", 32'(bus.CTRL), 32'h04);
    run_tab(4);
    @(negedge clk);
    bus.KBD_CS = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(30, 64'h0);
    o0 = ok_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    shift_bits(18, 64'h0);
    repeat (10) @(negedge clk);
    chk("midrst_ok", 32'(ok_cnt), 32'(o0));
    chk("midrst_err", 32'(err_cnt), 32'(e0));
    chk("midrst_ctrl", 32'(bus.CTRL), 32'h00);
    run_tab(5);
    bus.KBD_CS = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(48, f2);
    chk("midrst_fresh_ok", 32'(ok_cnt), 32'(o0 + 1));
    chk("midrst_fresh_ctrl", 32'(bus.CTRL), 32'h03);
    run_tab(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
